// File: rtl/instr_fetch_stage_pkg.sv
// Shared opcode constants, instruction field layout and fetch FSM encoding.
// The control unit imports this same package.
package instr_fetch_stage_pkg;

    localparam logic [4:0] OP_NOP = 5'b11111;
    localparam logic [4:0] OP_J   = 5'd16;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int IMM_HI = 14;
    localparam int IMM_LO = 0;

    // Packed in instruction bit order so a raw word casts straight to fields.
    typedef struct packed {
        logic [4:0]  opcode;  // [31:27]
        logic [3:0]  rd;      // [26:23]
        logic [3:0]  rs;      // [22:19]
        logic [3:0]  rt;      // [18:15]
        logic [14:0] imm;     // [14:0]
    } instr_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, neither means hold.
// A bubble keeps id_pc so the slot still reports where it came from.
module if_id_reg
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [4:0]  NOP_OPCODE = OP_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output instr_t      ir,
    output logic [31:0] id_pc,
    output logic        id_valid
);

    localparam instr_t BUB_IR = '{opcode: NOP_OPCODE, rd: 4'd0, rs: 4'd0, rt: 4'd0, imm: 15'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= BUB_IR;
            id_pc    <= RESET_PC;
            id_valid <= 1'b0;
        end else if (bubble) begin
            ir       <= BUB_IR;
            id_valid <= 1'b0;
        end else if (load) begin
            ir       <= instr_t'(instr);
            id_pc    <= pc;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, BOOT/FETCH/FLUSH sequencing and imem handshake,
// feeding the IF/ID register.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [4:0]  NOP_OPCODE = OP_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pc_select,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [14:0] imm,
    output logic [31:0] id_pc,
    output logic        id_valid
);

    fetch_state_e state, state_nx;
    logic [31:0]  pc, pc_nx;
    logic         ld, bub;
    instr_t       ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    // A redirect wins over stall and over any word returning the same cycle.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ld       = 1'b0;
        bub      = 1'b0;
        if (pc_select) begin
            pc_nx    = branch_target;
            bub      = 1'b1;
            state_nx = (state == ST_FETCH) ? ST_FLUSH : ST_FETCH;
        end else if (en) begin
            unique case (state)
                ST_BOOT, ST_FLUSH: begin
                    bub      = 1'b1;
                    state_nx = ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        ld = 1'b1;
                        if (imem_rdata[OPC_HI:OPC_LO] == OP_J) begin
                            pc_nx    = {17'b0, imem_rdata[IMM_HI:IMM_LO]};
                            state_nx = ST_FLUSH;
                        end else begin
                            pc_nx = pc + 32'd4;
                        end
                    end else begin
                        bub = 1'b1;
                    end
                end
                default: state_nx = ST_BOOT;
            endcase
        end
    end

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;

    if_id_reg #(
        .RESET_PC   (RESET_PC),
        .NOP_OPCODE (NOP_OPCODE)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .bubble   (bub),
        .instr    (imem_rdata),
        .pc       (pc),
        .ir       (ir),
        .id_pc    (id_pc),
        .id_valid (id_valid)
    );

    assign opcode = ir.opcode;
    assign rd     = ir.rd;
    assign rs     = ir.rs;
    assign rt     = ir.rt;
    assign imm    = ir.imm;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_instr_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] BUB    = {5'b11111, 27'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pc_select = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [4:0]  opcode;
    logic [3:0]  rd, rs, rt;
    logic [14:0] imm;
    logic [31:0] id_pc;
    logic        id_valid;

    int total = 0;
    int bad   = 0;

    instr_fetch_stage #(.RESET_PC(RST_PC), .NOP_OPCODE(5'b11111)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pc_select     (pc_select),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .opcode        (opcode),
        .rd            (rd),
        .rs            (rs),
        .rt            (rt),
        .imm           (imm),
        .id_pc         (id_pc),
        .id_valid      (id_valid)
    );

    always #5 clk = ~clk;

    // Model: m_idle counts cycles left before requests resume (reset and
    // redirects/jumps leave one idle cycle); m_ir is the word in IF/ID.
    int          m_idle;
    logic [31:0] m_pc, m_idpc, m_ir;
    logic        m_v;

    task automatic model_reset();
        m_idle = 1;
        m_pc   = RST_PC;
        m_idpc = RST_PC;
        m_ir   = BUB;
        m_v    = 1'b0;
    endtask

    task automatic model_update();
        if (pc_select) begin
            m_pc   = branch_target;
            m_ir   = BUB;
            m_v    = 1'b0;
            m_idle = (m_idle > 0) ? 0 : 1;
        end else if (en) begin
            if (m_idle > 0) begin
                m_idle = m_idle - 1;
                m_ir   = BUB;
                m_v    = 1'b0;
            end else if (imem_valid) begin
                m_ir   = imem_rdata;
                m_v    = 1'b1;
                m_idpc = m_pc;
                if (imem_rdata[31:27] == 5'd16) begin
                    m_pc   = {17'b0, imem_rdata[14:0]};
                    m_idle = 1;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end else begin
                m_ir = BUB;
                m_v  = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_req",  32'(imem_req), 32'(m_idle == 0));
        chk("imem_addr", imem_addr, m_pc);
        chk("opcode",    32'(opcode), 32'(m_ir[31:27]));
        chk("rd",        32'(rd),     32'(m_ir[26:23]));
        chk("rs",        32'(rs),     32'(m_ir[22:19]));
        chk("rt",        32'(rt),     32'(m_ir[18:15]));
        chk("imm",       32'(imm),    32'(m_ir[14:0]));
        chk("id_pc",     id_pc, m_idpc);
        chk("id_valid",  32'(id_valid), 32'(m_v));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic mid_cycle_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_req",  32'(imem_req), 32'd0);
        chk("rst_async_addr", imem_addr, RST_PC);
        compare_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        en = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h1080_0000;
        step();
        chk("reset_req",    32'(imem_req), 32'd0);
        chk("reset_addr",   imem_addr, 32'h0);
        chk("reset_opcode", 32'(opcode), 32'h1F);
        chk("reset_idv",    32'(id_valid), 32'd0);
        chk("reset_idpc",   id_pc, 32'h0);
        rst_n = 1'b1;
        step();                                    // BOOT: valid ignored
        chk("boot_addr0", imem_addr, 32'h0);
        chk("boot_idv",   32'(id_valid), 32'd0);
        step();
        chk("seq_op2",   32'(opcode), 32'd2);
        chk("seq_idpc0", id_pc, 32'h0);
        chk("seq_addr4", imem_addr, 32'h4);
        imem_rdata = 32'h0;
        step();
        chk("seq_op0",   32'(opcode), 32'd0);
        chk("seq_idpc4", id_pc, 32'h4);
        chk("seq_addr8", imem_addr, 32'h8);

        imem_rdata = 32'h0800_0001;
        step(); step();
        chk("wait_addr", imem_addr, 32'h10);
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_hold_addr", imem_addr, 32'h10);
            chk("wait_idv0",      32'(id_valid), 32'd0);
        end
        imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        chk("wait_cap_idv",  32'(id_valid), 32'd1);
        chk("wait_cap_idpc", id_pc, 32'h10);

        pc_select = 1'b1; branch_target = 32'h200; imem_rdata = 32'hDEAD_BEEF;
        step();
        pc_select = 1'b0;
        chk("br_bubble_op", 32'(opcode), 32'h1F);
        chk("br_bubble_v",  32'(id_valid), 32'd0);
        chk("br_flush_req", 32'(imem_req), 32'd0);
        step();
        chk("br_req",  32'(imem_req), 32'd1);
        chk("br_addr", imem_addr, 32'h200);

        en = 1'b0; imem_rdata = 32'h2222_3333;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_addr", imem_addr, 32'h200);
            chk("stall_op",   32'(opcode), 32'h1F);
            chk("stall_idv",  32'(id_valid), 32'd0);
            chk("stall_idpc", id_pc, 32'h10);
        end
        en = 1'b1;
        step();
        chk("stall_refetch_op",   32'(opcode), 32'd4);
        chk("stall_refetch_idpc", id_pc, 32'h200);

        pc_select = 1'b1; branch_target = 32'h8;
        step();
        pc_select = 1'b0;
        step();
        imem_rdata = 32'h8000_0040;
        step();
        chk("j_op",   32'(opcode), 32'd16);
        chk("j_idv",  32'(id_valid), 32'd1);
        chk("j_idpc", id_pc, 32'h8);
        chk("j_req",  32'(imem_req), 32'd0);
        imem_rdata = 32'h0;
        step();
        chk("j_bubble", 32'(opcode), 32'h1F);
        chk("j_addr",   imem_addr, 32'h40);
        chk("j_req2",   32'(imem_req), 32'd1);

        pc_select = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        pc_select = 1'b0;
        step();
        imem_rdata = 32'h0800_0001;
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        step();
        imem_valid = 1'b0;
        step();
        mid_cycle_reset();

        for (int i = 0; i < 3000; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            pc_select  = ($urandom_range(0, 11) == 0);
            branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            imem_valid = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            if ($urandom_range(0, 5) == 0) imem_rdata[31:27] = 5'd16;
            if ($urandom_range(0, 299) == 0) mid_cycle_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
